// File: rtl/ir_nec_pkg.sv
// Shared types and helpers for the NEC IR transmitter: FSM states, cycle
// constants derived from the system clock, and 32-bit frame assembly.
package ir_nec_pkg;

  typedef enum logic [3:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP,
    RPT_MARK,
    RPT_SPACE,
    RPT_STOP
  } state_t;

  // 64-bit arithmetic: CLK_HZ*1125 overflows 32 bits at 100 MHz.
  function automatic int unsigned t_lead_mark(longint unsigned hz);
    return 32'(hz * 9 / 1000);
  endfunction

  function automatic int unsigned t_lead_space(longint unsigned hz);
    return 32'(hz * 45 / 10000);
  endfunction

  function automatic int unsigned t_bit_mark(longint unsigned hz);
    return 32'(hz * 56 / 100000);
  endfunction

  function automatic int unsigned t_space0(longint unsigned hz);
    return 32'(hz * 1125 / 1000000 - hz * 56 / 100000);
  endfunction

  function automatic int unsigned t_space1(longint unsigned hz);
    return 32'(hz * 225 / 100000 - hz * 56 / 100000);
  endfunction

  function automatic int unsigned t_rpt_space(longint unsigned hz);
    return 32'(hz * 225 / 100000);
  endfunction

  function automatic int unsigned t_frame(longint unsigned hz);
    return 32'(hz * 108 / 1000);
  endfunction

  function automatic logic is_mark(state_t s);
    return s inside {LEAD_MARK, BIT_MARK, STOP_MARK, RPT_MARK, RPT_STOP};
  endfunction

  // Transmitted LSB first: address, address-inverse (or high address), cmd, ~cmd.
  function automatic logic [31:0] nec_frame(logic [15:0] addr, logic [7:0] cmd,
                                            logic ext);
    return {~cmd, cmd, (ext ? addr[15:8] : ~addr[7:0]), addr[7:0]};
  endfunction

endpackage

// File: rtl/ir_nec_tx_carrier.sv
// IR carrier generator: free-running phase counter that is parked at zero
// while disabled, so every enabled burst begins with a full high phase.
module ir_carrier #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned CARRIER_HZ = 38_000,
  parameter int unsigned DUTY_PCT   = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wave
);

  localparam int unsigned P  = CLK_HZ / CARRIER_HZ;
  localparam int unsigned H  = P * DUTY_PCT / 100;
  localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [PW-1:0] H_CNT  = PW'(H);

  logic [PW-1:0] phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (!en || phase == P_LAST) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign wave = en && (phase < H_CNT);

endmodule

// File: rtl/ir_nec_tx.sv
// NEC infrared transmitter: accepts a command over ready/valid, sends the
// leader, 32 data bits and stop mark, then optional repeat codes at 108 ms pitch.
module ir_nec_tx
  import ir_nec_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned CARRIER_HZ = 38_000,
  parameter int unsigned DUTY_PCT   = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] addr,
  input  logic [7:0]  cmd,
  input  logic        ext_mode,
  input  logic        repeat_en,
  output logic        busy,
  output logic        frame_done,
  output logic        ir_env,
  output logic        ir_led
);

  localparam longint unsigned HZ = 64'(CLK_HZ);

  localparam int unsigned T_LM = t_lead_mark(HZ);
  localparam int unsigned T_LS = t_lead_space(HZ);
  localparam int unsigned T_BM = t_bit_mark(HZ);
  localparam int unsigned T_S0 = t_space0(HZ);
  localparam int unsigned T_S1 = t_space1(HZ);
  localparam int unsigned T_RS = t_rpt_space(HZ);
  localparam int unsigned T_FR = t_frame(HZ);
  localparam int unsigned CW   = $clog2(T_FR + 1);

  localparam logic [CW-1:0] LM_LAST = CW'(T_LM - 1);
  localparam logic [CW-1:0] LS_LAST = CW'(T_LS - 1);
  localparam logic [CW-1:0] BM_LAST = CW'(T_BM - 1);
  localparam logic [CW-1:0] S0_LAST = CW'(T_S0 - 1);
  localparam logic [CW-1:0] S1_LAST = CW'(T_S1 - 1);
  localparam logic [CW-1:0] RS_LAST = CW'(T_RS - 1);
  localparam logic [CW-1:0] FR_LAST = CW'(T_FR - 1);

  state_t        state;
  state_t        next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] ftimer;
  logic [CW-1:0] last_cnt;
  logic [31:0]   frame;
  logic [4:0]    bit_idx;
  logic          accept;
  logic          phase_end;
  logic          gap_end;
  logic          carrier;

  assign s_ready    = (state == IDLE);
  assign busy       = (state != IDLE);
  assign accept     = s_valid && s_ready;
  assign phase_end  = (cnt == last_cnt);
  assign gap_end    = (ftimer == FR_LAST);
  assign frame_done = phase_end && (state == STOP_MARK || state == RPT_STOP);

  always_comb begin
    last_cnt = '0;
    case (state)
      LEAD_MARK, RPT_MARK:           last_cnt = LM_LAST;
      LEAD_SPACE:                    last_cnt = LS_LAST;
      BIT_MARK, STOP_MARK, RPT_STOP: last_cnt = BM_LAST;
      BIT_SPACE:                     last_cnt = frame[bit_idx] ? S1_LAST : S0_LAST;
      RPT_SPACE:                     last_cnt = RS_LAST;
      default:                       last_cnt = '0;
    endcase
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:       if (s_valid)   next = LEAD_MARK;
      LEAD_MARK:  if (phase_end) next = LEAD_SPACE;
      LEAD_SPACE: if (phase_end) next = BIT_MARK;
      BIT_MARK:   if (phase_end) next = BIT_SPACE;
      BIT_SPACE:  if (phase_end) next = (bit_idx == 5'd31) ? STOP_MARK : BIT_MARK;
      STOP_MARK:  if (phase_end) next = GAP;
      GAP:        if (gap_end)   next = repeat_en ? RPT_MARK : IDLE;
      RPT_MARK:   if (phase_end) next = RPT_SPACE;
      RPT_SPACE:  if (phase_end) next = RPT_STOP;
      RPT_STOP:   if (phase_end) next = GAP;
      default:                   next = IDLE;
    endcase
  end

  // Envelope is registered from the next state so it switches on the entry edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      ftimer  <= '0;
      frame   <= '0;
      bit_idx <= '0;
      ir_env  <= 1'b0;
    end else begin
      state  <= next;
      ir_env <= is_mark(next);

      if (next != state || next == IDLE) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (accept || next == IDLE || (state == GAP && next == RPT_MARK)) begin
        ftimer <= '0;
      end else begin
        ftimer <= ftimer + CW'(1);
      end

      if (accept) begin
        frame   <= nec_frame(addr, cmd, ext_mode);
        bit_idx <= '0;
      end else if (state == BIT_SPACE && phase_end) begin
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

  ir_carrier #(
    .CLK_HZ    (CLK_HZ),
    .CARRIER_HZ(CARRIER_HZ),
    .DUTY_PCT  (DUTY_PCT)
  ) u_carrier (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ir_env),
    .wave (carrier)
  );

  assign ir_led = ir_env & carrier;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx: random commands compared against a
// segment-list model of the NEC envelope built from the protocol timings.
module tb_ir_nec_tx;

  localparam int unsigned CLK_HZ     = 50_000;
  localparam int unsigned CARRIER_HZ = 5_000;
  localparam int unsigned DUTY       = 30;

  localparam int LM = CLK_HZ * 9 / 1000;
  localparam int LS = CLK_HZ * 45 / 10000;
  localparam int BM = CLK_HZ * 56 / 100000;
  localparam int S0 = CLK_HZ * 1125 / 1000000 - BM;
  localparam int S1 = CLK_HZ * 225 / 100000 - BM;
  localparam int RS = CLK_HZ * 225 / 100000;
  localparam int FR = CLK_HZ * 108 / 1000;
  localparam int P  = CLK_HZ / CARRIER_HZ;
  localparam int H  = P * DUTY / 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  cmd = '0;
  logic        ext_mode = 1'b0;
  logic        repeat_en = 1'b0;
  logic        s_ready, busy, frame_done, ir_env, ir_led;

  int n_tests = 0;
  int n_fail  = 0;

  int exp_lvl[$];
  int exp_len[$];
  int exp_done[$];
  int exp_total;

  always #5 clk = ~clk;

  ir_nec_tx #(
    .CLK_HZ    (CLK_HZ),
    .CARRIER_HZ(CARRIER_HZ),
    .DUTY_PCT  (DUTY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .addr      (addr),
    .cmd       (cmd),
    .ext_mode  (ext_mode),
    .repeat_en (repeat_en),
    .busy      (busy),
    .frame_done(frame_done),
    .ir_env    (ir_env),
    .ir_led    (ir_led)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic push_seg(input int lvl, input int len);
    exp_lvl.push_back(lvl);
    exp_len.push_back(len);
    exp_total += len;
  endtask

  // Envelope as (level, length) runs; gaps pad each transmission to FR cycles.
  task automatic build_model(input logic [15:0] a, input logic [7:0] c,
                             input logic e, input int nrep);
    logic [31:0] f;
    f = {~c, c, (e ? a[15:8] : ~a[7:0]), a[7:0]};
    exp_lvl.delete();
    exp_len.delete();
    exp_done.delete();
    exp_total = 0;
    push_seg(1, LM);
    push_seg(0, LS);
    for (int i = 0; i < 32; i++) begin
      push_seg(1, BM);
      push_seg(0, f[i] ? S1 : S0);
    end
    push_seg(1, BM);
    exp_done.push_back(exp_total);
    push_seg(0, FR - exp_total);
    for (int r = 1; r <= nrep; r++) begin
      push_seg(1, LM);
      push_seg(0, RS);
      push_seg(1, BM);
      exp_done.push_back(exp_total);
      push_seg(0, (r + 1) * FR - exp_total);
    end
  endtask

  function automatic int lvl_at(input int k);
    int acc = 0;
    for (int i = 0; i < exp_lvl.size(); i++) begin
      acc += exp_len[i];
      if (k <= acc) return exp_lvl[i];
    end
    return 0;
  endfunction

  task automatic send_and_check(input string name, input logic [15:0] a,
                                input logic [7:0] c, input logic e, input int nrep);
    int got_lvl[$];
    int got_len[$];
    int done_pos[$];
    int n, busy_n, cur, cur_len, mark_pos, led_err, hs_err, fb;
    int inj1, inj2, inj3;
    logic exp_led, timed_out;
    logic [31:0] exp_frame, dec;

    build_model(a, c, e, nrep);
    exp_frame = {~c, c, (e ? a[15:8] : ~a[7:0]), a[7:0]};
    inj1 = LM + LS + BM + 3;
    inj2 = FR - 50;
    inj3 = int'($urandom_range(1, FR - 100));

    @(negedge clk);
    check({name, "/ready_before"}, 64'(s_ready), 64'(1));
    addr = a;
    cmd = c;
    ext_mode = e;
    s_valid = 1'b1;
    @(posedge clk);

    n = 0; cur = -1; cur_len = 0; mark_pos = 0; led_err = 0; hs_err = 0;
    timed_out = 1'b1;
    while (n < exp_total + 50) begin
      @(negedge clk);
      n++;
      if (s_ready) begin
        timed_out = 1'b0;
        break;
      end
      if (int'(ir_env) != cur) begin
        if (cur_len > 0) begin
          got_lvl.push_back(cur);
          got_len.push_back(cur_len);
        end
        cur = int'(ir_env);
        cur_len = 1;
        mark_pos = 0;
      end else begin
        cur_len++;
        mark_pos++;
      end
      exp_led = ir_env && ((mark_pos % P) < H);
      if (ir_led !== exp_led) led_err++;
      if (busy !== 1'b1) hs_err++;
      if (frame_done === 1'b1) done_pos.push_back(n);
      s_valid = (n == inj1 || n == inj2 || n == inj3);
      if (s_valid) begin
        addr = 16'($urandom);
        cmd = 8'($urandom);
        ext_mode = 1'($urandom);
      end
      repeat_en = (n < nrep * FR + FR / 2);
    end
    s_valid = 1'b0;
    repeat_en = 1'b0;
    if (cur_len > 0) begin
      got_lvl.push_back(cur);
      got_len.push_back(cur_len);
    end
    busy_n = timed_out ? -1 : n - 1;

    check({name, "/busy_cycles"}, 64'(busy_n), 64'(exp_total));
    check({name, "/num_segments"}, 64'(got_lvl.size()), 64'(exp_lvl.size()));
    for (int i = 0; i < exp_lvl.size(); i++) begin
      fb = n_fail;
      check($sformatf("%s/seg%0d_lvl_len", name, i),
            (i < got_lvl.size()) ? 64'(got_lvl[i] * 1000000 + got_len[i]) : -64'sd1,
            64'(exp_lvl[i] * 1000000 + exp_len[i]));
      if (n_fail != fb) break;
    end
    dec = '0;
    for (int i = 0; i < 32; i++) begin
      if (3 + 2 * i < got_len.size()) dec[i] = (got_len[3 + 2 * i] > (S0 + S1) / 2);
    end
    check({name, "/decoded_bits"}, 64'(dec), 64'(exp_frame));
    check({name, "/frame_done_count"}, 64'(done_pos.size()), 64'(exp_done.size()));
    for (int i = 0; i < exp_done.size(); i++) begin
      check($sformatf("%s/frame_done_pos%0d", name, i),
            (i < done_pos.size()) ? 64'(done_pos[i]) : -64'sd1, 64'(exp_done[i]));
    end
    check({name, "/carrier_errors"}, 64'(led_err), 64'(0));
    check({name, "/busy_vs_ready_errors"}, 64'(hs_err), 64'(0));
    check({name, "/env_after"}, 64'(ir_env), 64'(0));
  endtask

  task automatic reset_mid(input string name, input int k);
    logic [15:0] a;
    logic [7:0]  c;
    a = 16'($urandom);
    c = 8'($urandom);
    build_model(a, c, 1'b0, 0);
    @(negedge clk);
    addr = a;
    cmd = c;
    ext_mode = 1'b0;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    repeat (k - 1) @(negedge clk);
    check({name, "/env_before_reset"}, 64'(ir_env), 64'(lvl_at(k)));
    #2 rst_n = 1'b0;
    #1;
    check({name, "/env_in_reset"}, 64'(ir_env), 64'(0));
    check({name, "/led_in_reset"}, 64'(ir_led), 64'(0));
    check({name, "/busy_in_reset"}, 64'(busy), 64'(0));
    check({name, "/ready_in_reset"}, 64'(s_ready), 64'(1));
    check({name, "/done_in_reset"}, 64'(frame_done), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check({name, "/ready_after_release"}, 64'(s_ready), 64'(1));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_seen;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset/s_ready", 64'(s_ready), 64'(1));
    check("reset/busy", 64'(busy), 64'(0));
    check("reset/ir_env", 64'(ir_env), 64'(0));
    check("reset/ir_led", 64'(ir_led), 64'(0));
    check("reset/frame_done", 64'(frame_done), 64'(0));
    rst_n = 1'b1;

    send_and_check("std", 16'h00A5, 8'h3C, 1'b0, 0);
    send_and_check("ext", 16'h1234, 8'h3C, 1'b1, 0);
    send_and_check("rpt2", 16'($urandom), 8'($urandom), 1'($urandom), 2);

    repeat_en = 1'b1;
    busy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy || ir_env) busy_seen++;
    end
    repeat_en = 1'b0;
    check("idle_repeat/activity", 64'(busy_seen), 64'(0));

    reset_mid("rst_lead_space", LM + int'($urandom_range(1, LS - 20)));
    send_and_check("post_rst1", 16'($urandom), 8'($urandom), 1'($urandom), 0);
    reset_mid("rst_bit_mark", LM + LS + BM / 2);
    send_and_check("post_rst2", 16'($urandom), 8'($urandom), 1'($urandom), 0);

    for (int t = 0; t < 3; t++) begin
      send_and_check($sformatf("rand%0d", t), 16'($urandom), 8'($urandom),
                     1'($urandom), int'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
